calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
- REQ-001: Parameters: none; operand width is fixed at 4 bits and result width at 8 bits.
- REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: ena  input  1  design enable; when low, all state (FSM, counters, registers, synchronisers) SHALL hold.
- REQ-005: ui_in  input  8  [3:0] operand nibble; [5:4] opcode (00 ADD, 01 SUB, 10 MUL, 11 DIV); [6] ENTER; [7] CLEAR.
- REQ-006: uo_out  output  8  result register.
- REQ-007: uio_in  input  8  unused; SHALL be ignored.
- REQ-008: uio_out  output  8  [0] busy; [1] done; [2] err; [4:3] state code; [7:5] zero.
- REQ-009: uio_oe  output  8  constant 8'h1F.

Function
- REQ-010: ENTER and CLEAR SHALL each pass through a 2-flop synchroniser; an event SHALL be one rising edge of the synchronised ENTER or CLEAR signal; a held level SHALL NOT retrigger.
- REQ-011: FSM states (code): IDLE=00, GOT_A=01, EXEC=10, DONE=11.
- REQ-012: IDLE + ENTER event -> capture A=ui_in[3:0] and op=ui_in[5:4]; go to GOT_A.
- REQ-013: GOT_A + ENTER event -> capture B=ui_in[3:0]; go to EXEC on the next cycle.
- REQ-014: EXEC cycle counts: ADD and SUB 1 cycle; MUL and DIV exactly 4 cycles; afterwards, go to DONE.
- REQ-015: ADD: result = {3'b0, A+B} (5-bit sum, zero-extended).
- REQ-016: SUB: result = A-B as 8-bit two's complement (3-5 = 8'hFE).
- REQ-017: MUL: unsigned shift-add, one partial product per cycle; result = 8-bit product.
- REQ-018: DIV: restoring division, one quotient bit per cycle; result = {remainder[3:0], quotient[3:0]}.
- REQ-019: DIV with B=0 SHALL set err=1 and result=8'hFF, and SHALL go to DONE after 1 EXEC cycle.
- REQ-020: busy=1 exactly while the state is EXEC.
- REQ-021: done=1 exactly while the state is DONE.
- REQ-022: uo_out SHALL update only on the EXEC->DONE transition, and SHALL hold otherwise.
- REQ-023: DONE + ENTER event -> capture a new A and op, clear done and err, go to GOT_A; uo_out SHALL keep the previous result until the next EXEC completes.
- REQ-024: ENTER events during EXEC SHALL be ignored.
- REQ-025: A CLEAR event in any state SHALL, on the next edge, force IDLE, uo_out=0, err=0, and the iteration counter to 0; CLEAR SHALL take priority over a simultaneous ENTER event.
- REQ-026: While ena=0, the iteration counter SHALL freeze, and EXEC SHALL resume without corruption when ena returns high.

Reset
- REQ-027: With rst_n low, the state SHALL be IDLE and the A, B, op, counter, uo_out, err and synchroniser flops SHALL all be 0, asynchronously.
- REQ-028: Assertion of rst_n mid-EXEC SHALL abort the operation immediately, with no partial result visible.
- REQ-029: Release of rst_n SHALL NOT itself generate an ENTER or CLEAR event, even if the pins are high at release.

Structure
- REQ-030: Package calc_pkg SHALL hold the opcode and FSM state encodings, the iteration count (4), and the divide-by-zero result constant 8'hFF.
- REQ-031: The MUL/DIV datapath SHALL be a sub-module calc_iter_unit, with start/step/done handshake inputs and outputs, driven by calc_sequencer.

Verification
- REQ-032: Reset -> uo_out=00, uio_out=00, uio_oe=1F; pins high at release -> still IDLE.
- REQ-033: A=7, B=9 ADD -> uo_out=10 after 1 busy cycle; A=3, B=5 SUB -> uo_out=FE.
- REQ-034: 15 MUL 15 -> busy high exactly 4 cycles, uo_out=E1, done=1; ENTER held high for 20 cycles -> exactly one capture.
- REQ-035: 13 DIV 4 -> uo_out=13; 9 DIV 0 -> err=1, uo_out=FF, one EXEC cycle.
- REQ-036: CLEAR together with ENTER mid-MUL -> IDLE, uo_out=00, busy=0; ena low for 3 cycles mid-DIV -> still 13 DIV 4 = 13.
- REQ-037: rst_n pulse in cycle 2 of MUL -> outputs 00 immediately; then a fresh 2 MUL 3 -> 06.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared opcode and FSM encodings plus iteration constants for the calculator
package calc_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, GOT_A = 2'b01, EXEC = 2'b10, DONE = 2'b11} state_e;
  localparam int ITERS = 4;
  localparam logic [7:0] DIV0_RES = 8'hFF;
endpackage

// File: rtl/calc_iter_unit.sv
// calc_iter_unit: iterative 4x4 shift-add multiply and restoring divide, one step per cycle
module calc_iter_unit
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       start,
  input  logic       step,
  input  logic       div,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       done,
  output logic [7:0] res
);
  logic [1:0] cnt;
  logic [3:0] a_q, b_q;
  logic       div_q, ge;
  logic [7:0] acc;
  logic [4:0] trial, diff;
  // For divide, acc holds {remainder, dividend/quotient}; res is the value after this step
  assign trial = {acc[7:4], acc[3]};
  assign diff  = trial - {1'b0, b_q};
  assign ge    = trial >= {1'b0, b_q};
  assign res   = div_q ? {ge ? diff[3:0] : trial[3:0], acc[2:0], ge}
                       : acc + (b_q[cnt] ? {4'b0, a_q} << cnt : 8'h00);
  assign done  = cnt == 2'(ITERS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      div_q <= 1'b0;
      acc <= '0;
    end else if (clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (start) begin
      cnt <= '0;
      a_q <= a;
      b_q <= b;
      div_q <= div;
      acc <= div ? {4'b0, a} : 8'h00;
    end else if (step) begin
      cnt <= cnt + 2'd1;
      acc <= res;
    end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: two-operand calculator FSM driven by synchronised ENTER/CLEAR pin events
module calc_sequencer
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  state_e     state;
  op_e        op;
  logic [3:0] a, b;
  logic [1:0] ent_s, clr_s;
  logic       err, ent_q, clr_q, ent_arm, clr_arm;
  logic       ent_ev, clr_ev, div0, iter_done, exec_done, unused_uio;
  logic [7:0] iter_res, exec_res;
  // Arm flags require a low level after reset, so pins held high at release never fire
  assign ent_ev    = ent_s[1] & ~ent_q & ent_arm;
  assign clr_ev    = clr_s[1] & ~clr_q & clr_arm;
  assign div0      = op == OP_DIV && b == 4'd0;
  assign exec_done = ~op[1] | div0 | iter_done;
  assign exec_res  = op == OP_ADD ? {3'b0, {1'b0, a} + {1'b0, b}}
                   : op == OP_SUB ? {4'b0, a} - {4'b0, b}
                   : div0         ? DIV0_RES
                   : iter_res;
  assign uio_out    = {3'b0, state, err, state == DONE, state == EXEC};
  assign uio_oe     = 8'h1F;
  assign unused_uio = ^uio_in;
  calc_iter_unit u_iter (
    .clk(clk),
    .rst_n(rst_n),
    .clr(ena & clr_ev),
    .start(ena & ent_ev & ~clr_ev & state == GOT_A),
    .step(ena & ~clr_ev & state == EXEC & op[1] & ~div0),
    .div(op == OP_DIV),
    .a(a),
    .b(ui_in[3:0]),
    .done(iter_done),
    .res(iter_res)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op <= OP_ADD;
      a <= '0;
      b <= '0;
      err <= 1'b0;
      uo_out <= '0;
      ent_s <= '0;
      clr_s <= '0;
      ent_q <= 1'b0;
      clr_q <= 1'b0;
      ent_arm <= 1'b0;
      clr_arm <= 1'b0;
    end else if (ena) begin
      ent_s <= {ent_s[0], ui_in[6]};
      clr_s <= {clr_s[0], ui_in[7]};
      ent_q <= ent_s[1];
      clr_q <= clr_s[1];
      ent_arm <= ent_arm | ~ent_s[1];
      clr_arm <= clr_arm | ~clr_s[1];
      if (clr_ev) begin
        state <= IDLE;
        uo_out <= '0;
        err <= 1'b0;
      end else if (state == EXEC) begin
        if (exec_done) begin
          state <= DONE;
          uo_out <= exec_res;
          err <= div0;
        end
      end else if (ent_ev) begin
        if (state == GOT_A) begin
          b <= ui_in[3:0];
          state <= EXEC;
        end else begin
          a <= ui_in[3:0];
          op <= op_e'(ui_in[5:4]);
          err <= 1'b0;
          state <= GOT_A;
        end
      end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench for calc_sequencer
module tb_calc_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0, errors = 0, busy_n = 0;

  calc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] nib, input logic [1:0] op);
    ui_in = {1'b0, 1'b1, op, nib};
    cyc(4);
    ui_in[6] = 1'b0;
    cyc(3);
  endtask

  task automatic run(input logic [3:0] nib);
    bit got;
    got = 0;
    busy_n = 0;
    ui_in = {1'b0, 1'b1, ui_in[5:4], nib};
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (uio_out[0]) busy_n++;
      if (uio_out[1]) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL run_timeout: done never seen, busy cycles %0d", busy_n);
    end
    ui_in[6] = 1'b0;
    cyc(3);
  endtask

  task automatic test_reset;
    ui_in = 8'hC0;
    cyc(2);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo: got %h want 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio: got %h want 00", uio_out); end
    checks++; if (uio_oe !== 8'h1F) begin errors++; $display("FAIL reset_oe: got %h want 1F", uio_oe); end
    rst_n = 1'b1;
    cyc(6);
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL release_idle: got %h want 00", uio_out); end
    ui_in = 8'h00;
    cyc(3);
  endtask

  task automatic test_add_sub;
    press(4'd7, 2'b00);
    run(4'd9);
    checks++; if (uo_out !== 8'h10) begin errors++; $display("FAIL add_res: got %h want 10", uo_out); end
    checks++; if (busy_n !== 1) begin errors++; $display("FAIL add_busy: got %0d want 1", busy_n); end
    checks++; if (uio_out !== 8'h1A) begin errors++; $display("FAIL add_status: got %h want 1A", uio_out); end
    press(4'd3, 2'b01);
    run(4'd5);
    checks++; if (uo_out !== 8'hFE) begin errors++; $display("FAIL sub_res: got %h want FE", uo_out); end
  endtask

  task automatic test_mul;
    ui_in = {1'b0, 1'b1, 2'b10, 4'hF};
    cyc(20);
    checks++; if (uio_out !== 8'h08) begin errors++; $display("FAIL mul_hold_state: got %h want 08", uio_out); end
    ui_in[6] = 1'b0;
    cyc(3);
    checks++; if (uio_out !== 8'h08) begin errors++; $display("FAIL mul_one_capture: got %h want 08", uio_out); end
    run(4'hF);
    checks++; if (uo_out !== 8'hE1) begin errors++; $display("FAIL mul_res: got %h want E1", uo_out); end
    checks++; if (busy_n !== 4) begin errors++; $display("FAIL mul_busy: got %0d want 4", busy_n); end
    checks++; if (uio_out[1] !== 1'b1) begin errors++; $display("FAIL mul_done: got %b want 1", uio_out[1]); end
  endtask

  task automatic test_back_to_back;
    press(4'd13, 2'b11);
    checks++; if (uo_out !== 8'hE1) begin errors++; $display("FAIL b2b_hold: got %h want E1", uo_out); end
    checks++; if (uio_out !== 8'h08) begin errors++; $display("FAIL b2b_state: got %h want 08", uio_out); end
    run(4'd4);
    checks++; if (uo_out !== 8'h13) begin errors++; $display("FAIL div_res: got %h want 13", uo_out); end
    checks++; if (busy_n !== 4) begin errors++; $display("FAIL div_busy: got %0d want 4", busy_n); end
  endtask

  task automatic test_div0;
    press(4'd9, 2'b11);
    run(4'd0);
    checks++; if (uo_out !== 8'hFF) begin errors++; $display("FAIL div0_res: got %h want FF", uo_out); end
    checks++; if (uio_out !== 8'h1E) begin errors++; $display("FAIL div0_status: got %h want 1E", uio_out); end
    checks++; if (busy_n !== 1) begin errors++; $display("FAIL div0_busy: got %0d want 1", busy_n); end
  endtask

  task automatic test_clear;
    press(4'hF, 2'b10);
    checks++; if (uio_out !== 8'h08) begin errors++; $display("FAIL clr_err_cleared: got %h want 08", uio_out); end
    checks++; if (uo_out !== 8'hFF) begin errors++; $display("FAIL clr_prev_hold: got %h want FF", uo_out); end
    ui_in = {1'b0, 1'b1, 2'b10, 4'hF};
    cyc(2);
    ui_in[6] = 1'b0;
    cyc(1);
    checks++; if (uio_out !== 8'h11) begin errors++; $display("FAIL clr_in_exec: got %h want 11", uio_out); end
    ui_in = {1'b1, 1'b1, 2'b10, 4'hF};
    cyc(3);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL clr_uo: got %h want 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL clr_status: got %h want 00", uio_out); end
    cyc(6);
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL clr_held: got %h want 00", uio_out); end
    ui_in = 8'h00;
    cyc(3);
  endtask

  task automatic test_ena;
    bit got;
    press(4'd13, 2'b11);
    ui_in = {1'b0, 1'b1, 2'b11, 4'd4};
    cyc(4);
    ena = 1'b0;
    cyc(3);
    checks++; if (uio_out !== 8'h11) begin errors++; $display("FAIL ena_frozen: got %h want 11", uio_out); end
    ena = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (uio_out[1]) got = 1;
    end
    ui_in[6] = 1'b0;
    cyc(3);
    checks++; if (uo_out !== 8'h13) begin errors++; $display("FAIL ena_div_res: got %h want 13", uo_out); end
  endtask

  task automatic test_rst_mid;
    press(4'hF, 2'b10);
    ui_in = {1'b0, 1'b1, 2'b10, 4'hF};
    cyc(4);
    rst_n = 1'b0;
    #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL rst_mid_uo: got %h want 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL rst_mid_uio: got %h want 00", uio_out); end
    ui_in = 8'h00;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    press(4'd2, 2'b10);
    run(4'd3);
    checks++; if (uo_out !== 8'h06) begin errors++; $display("FAIL fresh_mul_res: got %h want 06", uo_out); end
    checks++; if (busy_n !== 4) begin errors++; $display("FAIL fresh_mul_busy: got %0d want 4", busy_n); end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_mul;
    test_back_to_back;
    test_div0;
    test_clear;
    test_ena;
    test_rst_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
